instmem_loader: RTL and testbench
=================================

# instmem_loader

Instruction-memory responder and UART program loader for the single-cycle MIPS core. It serves the fetch unit's word-address read port, returning one 32-bit instruction per cycle. It also accepts a byte stream from the UART receiver, packs it into little-endian words and writes them into the same memory, holding the CPU while a load is in progress.

## Interface
- ADDR_W, 14, word-address width; memory depth is 2^ADDR_W words
- TIMEOUT_CYC, 100000, idle cycles after the last byte that end a load
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- rom_adr_i  input  ADDR_W  word address from the fetch unit (PC[15:2])
- Instruction_o  output  32  instruction at the registered address
- rx_byte  input  8  received UART byte
- rx_valid  input  1  one-cycle strobe; rx_byte is valid in this cycle
- load_req  input  1  one-cycle request to start a load (debounced button)
- cpu_hold  output  1  high while loading; the CPU is held in reset by it
- load_done  output  1  one-cycle pulse when a load completes
- word_count  output  ADDR_W+1  number of words written by the last or current load

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE → LOAD on load_req. The byte lane, write pointer, word_count and idle counter all clear.
- LOAD packs bytes little-endian: the first byte goes to [7:0], the fourth to [31:24].
- After the 4th byte, the word is written at the write pointer. The pointer and word_count then increment and the lane counter returns to 0.
- LOAD → DONE when either:
  - the idle counter reaches TIMEOUT_CYC with at least one byte received, or
  - the write pointer wraps after writing word 2^ADDR_W−1 (memory full). Bytes after that are dropped.
- Partial word at timeout: it is written with the missing upper bytes zero, and word_count counts it.
- With zero bytes received, LOAD stays in LOAD indefinitely. The idle counter does not run until the first byte arrives.
- DONE → IDLE after one cycle; load_done is high during DONE.
- cpu_hold is high in LOAD and DONE and low in IDLE.
- load_req in LOAD or DONE is ignored.
- Fetch reads:
  - In IDLE, Instruction_o returns memory[rom_adr_i].
  - In LOAD or DONE, Instruction_o returns 32'h0000_0000 (NOP).
- The memory is single-write, single-read. There are no read-write collisions, because reads are masked while writes are possible.

## Timing
- Reset values:
  - state IDLE
  - cpu_hold 0, load_done 0
  - Instruction_o 0, word_count 0
  - pointer, lane and idle counters 0
- Memory contents are not cleared by reset.
- Read latency: 1 cycle. Instruction_o updates on the rising edge after rom_adr_i is presented. The fetch unit updates the PC on the falling edge, so data is ready within the same CPU cycle.
- Write latency: the memory write occurs on the edge after the 4th rx_valid. word_count increments on the same edge.
- rx_valid in the same cycle the idle counter would expire: the byte is accepted, the counter clears and no timeout fires.
- Timeout partial-word write and the LOAD→DONE transition occur on the same edge.
- Reset asserted mid-load:
  - immediate return to IDLE with cpu_hold low
  - words already written are kept, and no partial word is written.
- Back-to-back rx_valid on consecutive cycles is supported.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - adds output load_csum[31:0], the running XOR of every word written in the current load (including a padded partial word).
  - It clears on entry to LOAD and holds its value in IDLE.
- LOADER_CHECKSUM_EN not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, LOAD, DONE)
  - NOP constant 32'h0000_0000
  - default ADDR_W and TIMEOUT_CYC
- One sub-module, instmem_ram: an ADDR_W×32 array with a synchronous write port and a synchronous registered read port, inferring block RAM.
- The FSM, byte packer, counters and read mask sit in the top module.

## Test plan
- Preload: reset, load_req, bytes 78 56 34 12 EF BE AD DE, then TIMEOUT_CYC idle → memory[0]=12345678, memory[1]=DEADBEEF, word_count=2, one load_done pulse, cpu_hold falls the cycle after.
- Partial word: load 5 bytes 01 02 03 04 AA, then timeout → memory[1]=000000AA, word_count=2.
- Fetch: in IDLE, rom_adr_i=1 → Instruction_o=DEADBEEF one edge later. During LOAD, any address → 00000000.
- Timeout race: during LOAD, rx_valid arrives on the exact expiry cycle → no load_done, and the load continues.
- Full: with ADDR_W=4, stream 68 bytes → 16 words written, DONE entered on the wrap, extra bytes ignored, word_count=16.
- Reset mid-load after 6 bytes → IDLE, cpu_hold 0, memory[0] kept, memory[1] unchanged. With LOADER_CHECKSUM_EN, load_csum of the preload case = 12345678^DEADBEEF = CC99E897.

Source files
------------

// File: rtl/instmem_loader_pkg.sv
// Shared types and defaults for the instruction memory / UART program loader.
// Optional checksum output is enabled by defining LOADER_CHECKSUM_EN.
package instmem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } ld_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_TIMEOUT_CYC = 100000;

  function automatic logic [31:0] put_byte(
    input logic [31:0] w,
    input logic [1:0]  lane,
    input logic [7:0]  b
  );
    return w | ({24'b0, b} << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/instmem_ram.sv
// Single-write, single-read instruction store with a registered read port.
// Maps onto block RAM; contents are deliberately not reset.
module instmem_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instmem_loader.sv
// Instruction fetch responder plus UART byte-stream program loader.
// Define LOADER_CHECKSUM_EN to add the load_csum output.
module instmem_loader
  import instmem_loader_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rom_adr_i,
  output logic [31:0]       Instruction_o,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              load_req,
  output logic              cpu_hold,
  output logic              load_done,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]       load_csum,
`endif
  output logic [ADDR_W:0]   word_count
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  ld_state_e         state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic              seen_q, seen_d;
  logic              rd_ok_q;

  logic        we;
  logic [31:0] wdata;
  logic [31:0] merged;
  logic        re;
  logic [31:0] rdata;

  assign merged = put_byte(word_q, lane_q, rx_byte);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    seen_d  = seen_q;
    we      = 1'b0;
    wdata   = word_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d = ST_LOAD;
          lane_d  = '0;
          word_d  = '0;
          ptr_d   = '0;
          cnt_d   = '0;
          idle_d  = '0;
          seen_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (rx_valid) begin
          seen_d = 1'b1;
          idle_d = '0;
          if (lane_q == 2'd3) begin
            we     = 1'b1;
            wdata  = merged;
            word_d = '0;
            lane_d = '0;
            ptr_d  = ptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (&ptr_q) state_d = ST_DONE;
          end else begin
            word_d = merged;
            lane_d = lane_q + 2'd1;
          end
        end else if (seen_q) begin
          // Idle timeout flushes any partial word, upper bytes already zero.
          if (idle_q == IDLE_LAST) begin
            state_d = ST_DONE;
            lane_d  = '0;
            word_d  = '0;
            if (lane_q != 2'd0) begin
              we    = 1'b1;
              ptr_d = ptr_q + 1'b1;
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads only run when no write can happen in the same cycle.
  assign re = (state_d == ST_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      seen_q  <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      seen_q  <= seen_d;
      rd_ok_q <= re;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE && load_req) csum_d = '0;
    else if (we) csum_d = csum_q ^ wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) csum_q <= '0;
    else csum_q <= csum_d;
  end

  assign load_csum = csum_q;
`endif

  instmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_i   (clock),
    .we_i    (we),
    .waddr_i (ptr_q),
    .wdata_i (wdata),
    .re_i    (re),
    .raddr_i (rom_adr_i),
    .rdata_o (rdata)
  );

  assign Instruction_o = rd_ok_q ? rdata : NOP;
  assign cpu_hold      = (state_q != ST_IDLE);
  assign load_done     = (state_q == ST_DONE);
  assign word_count    = cnt_q;

endmodule

// File: tb/tb_instmem_loader.sv
// Scoreboard bench for instmem_loader, small memory and short timeout.
// Checks load_csum too when LOADER_CHECKSUM_EN is defined.
module tb_instmem_loader;

  localparam int AW    = 4;
  localparam int TO    = 16;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] rom_adr_i = '0;
  logic [31:0]   Instruction_o;
  logic [7:0]    rx_byte = '0;
  logic          rx_valid = 1'b0;
  logic          load_req = 1'b0;
  logic          cpu_hold;
  logic          load_done;
  logic [AW:0]   word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   load_csum;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_mem [DEPTH];
  logic [31:0] sb_q [$];

  always #5 clock = ~clock;

  instmem_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clock         (clock),
    .reset         (reset),
    .rom_adr_i     (rom_adr_i),
    .Instruction_o (Instruction_o),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .load_req      (load_req),
    .cpu_hold      (cpu_hold),
    .load_done     (load_done),
`ifdef LOADER_CHECKSUM_EN
    .load_csum     (load_csum),
`endif
    .word_count    (word_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (load_done !== 1'b1 && cycles < 64) begin
      step();
      cycles++;
    end
  endtask

  task automatic fetch_check(input int lo, input int hi, input string tag);
    logic [31:0] exp;
    for (int a = lo; a <= hi; a++) begin
      rom_adr_i = AW'(a);
      sb_q.push_back(exp_mem[a]);
      step();
      exp = sb_q.pop_front();
      vectors++;
      if (Instruction_o !== exp) begin
        errors++;
        $display("FAIL %s fetch[%0d]: got %h want %h", tag, a, Instruction_o, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    vectors++;
    if (cpu_hold !== 1'b0) begin
      errors++; $display("FAIL reset cpu_hold: got %b want 0", cpu_hold);
    end
    vectors++;
    if (load_done !== 1'b0) begin
      errors++; $display("FAIL reset load_done: got %b want 0", load_done);
    end
    vectors++;
    if (Instruction_o !== 32'h0) begin
      errors++; $display("FAIL reset instr: got %h want 0", Instruction_o);
    end
    vectors++;
    if (word_count !== '0) begin
      errors++; $display("FAIL reset word_count: got %0d want 0", word_count);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_preload();
    int cyc;
    start_load();
    vectors++;
    if (cpu_hold !== 1'b1) begin
      errors++; $display("FAIL preload hold: got %b want 1", cpu_hold);
    end
    rom_adr_i = AW'(1);
    step();
    vectors++;
    if (Instruction_o !== 32'h0) begin
      errors++; $display("FAIL load nop: got %h want 0", Instruction_o);
    end
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    vectors++;
    if (word_count !== 5'd1) begin
      errors++; $display("FAIL preload wc1: got %0d want 1", word_count);
    end
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    wait_done(cyc);
    vectors++;
    if (cyc != TO) begin
      errors++; $display("FAIL preload timeout: got %0d want %0d", cyc, TO);
    end
    vectors++;
    if (word_count !== 5'd2) begin
      errors++; $display("FAIL preload wc: got %0d want 2", word_count);
    end
`ifdef LOADER_CHECKSUM_EN
    vectors++;
    if (load_csum !== 32'hCC99E897) begin
      errors++; $display("FAIL preload csum: got %h want CC99E897", load_csum);
    end
`endif
    step();
    vectors++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL preload end: got done=%b hold=%b want 0 0", load_done, cpu_hold);
    end
    exp_mem[0] = 32'h12345678;
    exp_mem[1] = 32'hDEADBEEF;
    fetch_check(1, 1, "preload");
    fetch_check(0, 1, "preload");
  endtask

  task automatic test_partial();
    int cyc;
    start_load();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hAA);
    wait_done(cyc);
    vectors++;
    if (cyc != TO) begin
      errors++; $display("FAIL partial timeout: got %0d want %0d", cyc, TO);
    end
    vectors++;
    if (word_count !== 5'd2) begin
      errors++; $display("FAIL partial wc: got %0d want 2", word_count);
    end
    step();
    exp_mem[0] = 32'h04030201;
    exp_mem[1] = 32'h000000AA;
    fetch_check(0, 1, "partial");
  endtask

  task automatic test_timeout_race();
    int cyc;
    int early;
    early = 0;
    start_load();
    send(8'h11);
    repeat (TO - 1) begin
      step();
      if (load_done === 1'b1) early++;
    end
    send(8'h22);
    vectors++;
    if (early != 0 || load_done !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL race: got early=%0d done=%b hold=%b want 0 0 1", early, load_done, cpu_hold);
    end
    send(8'h33); send(8'h44);
    vectors++;
    if (word_count !== 5'd1) begin
      errors++; $display("FAIL race wc: got %0d want 1", word_count);
    end
    wait_done(cyc);
    vectors++;
    if (cyc != TO) begin
      errors++; $display("FAIL race timeout: got %0d want %0d", cyc, TO);
    end
    step();
    exp_mem[0] = 32'h44332211;
    fetch_check(0, 0, "race");
  endtask

  function automatic logic [7:0] full_byte(input int k);
    return 8'((k * 7) + 3);
  endfunction

  task automatic test_full();
    start_load();
    for (int k = 0; k < 4 * DEPTH; k++) send(full_byte(k));
    vectors++;
    if (load_done !== 1'b1 || word_count !== 5'd16) begin
      errors++;
      $display("FAIL full wrap: got done=%b wc=%0d want 1 16", load_done, word_count);
    end
    for (int k = 0; k < 4; k++) send(8'hF0 + 8'(k));
    vectors++;
    if (cpu_hold !== 1'b0 || word_count !== 5'd16) begin
      errors++;
      $display("FAIL full after: got hold=%b wc=%0d want 0 16", cpu_hold, word_count);
    end
    for (int i = 0; i < DEPTH; i++)
      exp_mem[i] = {full_byte(4*i+3), full_byte(4*i+2), full_byte(4*i+1), full_byte(4*i)};
    fetch_check(0, DEPTH - 1, "full");
  endtask

  task automatic test_reset_mid();
    start_load();
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    send(8'hB1); send(8'hB2);
    vectors++;
    if (word_count !== 5'd1) begin
      errors++; $display("FAIL mid wc: got %0d want 1", word_count);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (cpu_hold !== 1'b0 || load_done !== 1'b0 || word_count !== '0) begin
      errors++;
      $display("FAIL mid reset: got hold=%b done=%b wc=%0d want 0 0 0", cpu_hold, load_done, word_count);
    end
    step();
    reset = 1'b1;
    step();
    exp_mem[0] = 32'hA4A3A2A1;
    fetch_check(0, 2, "midreset");
  endtask

  initial begin
    test_reset();
    test_preload();
    test_partial();
    test_timeout_race();
    test_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
